// File: rtl/cps_gpu_vram_fetch.sv
// VRAM burst fetcher: issues GPU-slot reads to the SRAM controller under a FIFO credit limit
// and streams the returned words out in order, flagging the final word of each burst.
module cps_gpu_vram_fetch (
    input  logic        bus_clk,
    input  logic        bus_rst,
    input  logic [3:0]  ram_cyc,
    input  logic [3:0]  ram_acc,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [19:0] req_addr,
    input  logic [4:0]  req_len,
    output logic        gpu_rden,
    output logic [19:0] gpu_addr,
    input  logic [31:0] gpu_rdata,
    input  logic        gpu_valid,
    output logic        dat_valid,
    input  logic        dat_ready,
    output logic [31:0] dat_data,
    output logic        dat_last,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [17:0] word_addr;
    logic [5:0]  remaining;
    logic [5:0]  burst_len;
    logic [5:0]  rcv_count;
    logic [3:0]  outstanding;
    logic [3:0]  fifo_count;
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic [32:0] fifo_mem [8];

    logic        gpu_slot;
    logic [4:0]  credit_used;
    logic        issue;
    logic        push;
    logic        push_last;
    logic        pop;
    logic        accept;
    logic        last_pop;
    logic        unused_bits;

    assign gpu_slot    = ram_acc[1] | ram_acc[3];
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    // A read counts only where the SRAM controller samples it: phase 0 of a GPU-owned slot.
    assign issue       = ram_cyc[0] & gpu_slot & gpu_rden;
    assign push        = gpu_valid & (outstanding != 4'd0);
    assign push_last   = (rcv_count + 6'd1) == burst_len;
    assign pop         = dat_valid & dat_ready;
    assign accept      = req_valid & req_ready;
    assign last_pop    = pop & dat_last;
    assign unused_bits = ^{ram_cyc[3:1], ram_acc[2], ram_acc[0], req_addr[1:0]};

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = FETCH;
            FETCH:   if (issue && remaining == 6'd1) state_nxt = DRAIN;
            DRAIN:   if (last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        gpu_rden  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            FETCH:   gpu_rden = (remaining != 6'd0) && (credit_used < 5'd8);
            default: ;
        endcase
    end

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            word_addr   <= '0;
            remaining   <= '0;
            burst_len   <= '0;
            rcv_count   <= '0;
            outstanding <= '0;
        end else begin
            if (accept) begin
                word_addr <= req_addr[19:2];
                burst_len <= {1'b0, req_len} + 6'd1;
                remaining <= {1'b0, req_len} + 6'd1;
                rcv_count <= '0;
            end else begin
                if (issue) begin
                    word_addr <= word_addr + 18'd1;
                    remaining <= remaining - 6'd1;
                end
                if (push) rcv_count <= rcv_count + 6'd1;
            end
            case ({issue, push})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 3'd1;
            if (pop)  rd_ptr <= rd_ptr + 3'd1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 4'd1;
                2'b01:   fifo_count <= fifo_count - 4'd1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count define which entries are valid.
    always_ff @(posedge bus_clk) begin
        if (push) fifo_mem[wr_ptr] <= {push_last, gpu_rdata};
    end

    assign gpu_addr  = {word_addr, 2'b00};
    assign dat_valid = (fifo_count != 4'd0);
    assign dat_data  = dat_valid ? fifo_mem[rd_ptr][31:0] : 32'd0;
    assign dat_last  = dat_valid & fifo_mem[rd_ptr][32];

endmodule

// File: tb/tb_cps_gpu_vram_fetch.sv
// Bench for cps_gpu_vram_fetch: SRAM-controller model with fixed return latency plus
// address and word scoreboards filled when each burst request is driven.
module tb_cps_gpu_vram_fetch;

    localparam int LAT = 5;

    logic        bus_clk = 1'b0;
    logic        bus_rst;
    logic [3:0]  ram_cyc;
    logic [3:0]  ram_acc;
    logic        req_valid;
    logic        req_ready;
    logic [19:0] req_addr;
    logic [4:0]  req_len;
    logic        gpu_rden;
    logic [19:0] gpu_addr;
    logic [31:0] gpu_rdata;
    logic        gpu_valid;
    logic        dat_valid;
    logic        dat_ready;
    logic [31:0] dat_data;
    logic        dat_last;
    logic        busy;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    ret_t        pending[$];
    word_t       exp_q[$];
    logic [19:0] exp_addr[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          issue_cnt = 0;
    int          pop_cnt = 0;
    bit          slot_en;
    bit          spurious_en;
    logic [31:0] spur_data;
    bit          gv_driven;
    bit          did_pop;
    bit          did_pop_last;
    bit          did_issue;

    cps_gpu_vram_fetch dut (
        .bus_clk   (bus_clk),
        .bus_rst   (bus_rst),
        .ram_cyc   (ram_cyc),
        .ram_acc   (ram_acc),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .gpu_rden  (gpu_rden),
        .gpu_addr  (gpu_addr),
        .gpu_rdata (gpu_rdata),
        .gpu_valid (gpu_valid),
        .dat_valid (dat_valid),
        .dat_ready (dat_ready),
        .dat_data  (dat_data),
        .dat_last  (dat_last),
        .busy      (busy)
    );

    always #5 bus_clk = ~bus_clk;

    function automatic logic [31:0] mem_word(input logic [19:0] a);
        if (a == 20'h01234) return 32'hDEADBEEF;
        return {a[19:2], 14'h0} ^ 32'h5A3C_96E1;
    endfunction

    // One bus_clk: drive inputs for the next edge, score issue/pop, end at the falling edge.
    task automatic tick();
        ret_t        r;
        word_t       w;
        logic [19:0] a;
        cyc++;
        ram_cyc      = {ram_cyc[2:0], ram_cyc[3]};
        ram_acc      = slot_en ? 4'b1010 : 4'b0101;
        gv_driven    = 1'b0;
        did_pop      = 1'b0;
        did_pop_last = 1'b0;
        did_issue    = 1'b0;
        if (pending.size() != 0 && pending[0].due <= cyc) begin
            r         = pending.pop_front();
            gpu_valid = 1'b1;
            gpu_rdata = r.data;
            gv_driven = 1'b1;
        end else if (spurious_en) begin
            gpu_valid = 1'b1;
            gpu_rdata = spur_data;
            gv_driven = 1'b1;
        end else begin
            gpu_valid = 1'b0;
            gpu_rdata = $urandom;
        end
        if (ram_cyc[0] && (ram_acc[1] || ram_acc[3]) && gpu_rden === 1'b1) begin
            did_issue = 1'b1;
            issue_cnt++;
            pending.push_back('{cyc + LAT, mem_word(gpu_addr)});
            n_cmp++;
            if (exp_addr.size() == 0) begin
                n_err++;
                $display("FAIL issue_addr: unexpected issue at gpu_addr=%h, none required", gpu_addr);
            end else begin
                a = exp_addr.pop_front();
                if (gpu_addr !== a) begin
                    n_err++;
                    $display("FAIL issue_addr: gpu_addr=%h required=%h", gpu_addr, a);
                end
            end
        end
        if (dat_valid === 1'b1 && dat_ready === 1'b1) begin
            did_pop      = 1'b1;
            did_pop_last = dat_last;
            pop_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_word: unexpected word data=%h last=%b, none required", dat_data, dat_last);
            end else begin
                w = exp_q.pop_front();
                if (dat_data !== w.data || dat_last !== w.last) begin
                    n_err++;
                    $display("FAIL out_word: data=%h last=%b required data=%h last=%b",
                             dat_data, dat_last, w.data, w.last);
                end
            end
        end
        @(posedge bus_clk);
        @(negedge bus_clk);
    endtask

    task automatic push_expect(input logic [19:0] a, input logic [4:0] len);
        logic [19:0] wa;
        wa = {a[19:2], 2'b00};
        for (int i = 0; i <= int'(len); i++) begin
            exp_addr.push_back(wa);
            exp_q.push_back('{mem_word(wa), (i == int'(len))});
            wa = wa + 20'd4;
        end
    endtask

    task automatic start_burst(input logic [19:0] a, input logic [4:0] len);
        bit acc;
        push_expect(a, len);
        req_addr  = a;
        req_len   = len;
        req_valid = 1'b1;
        acc       = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = (req_ready === 1'b1);
            tick();
        end
        req_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_err++;
            $display("FAIL req_accept: request %h not accepted within 20 cycles, required acceptance", a);
        end
    endtask

    task automatic drain(input string name, input int bound);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && k < bound) begin
            tick();
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_drain: %0d words left busy=%b, required 0 words busy=0", name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        bus_rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: req_ready=%b busy=%b required 1 0", req_ready, busy);
        end
        n_cmp++;
        if (gpu_rden !== 1'b0 || gpu_addr !== 20'h0) begin
            n_err++;
            $display("FAIL reset_gpu: gpu_rden=%b gpu_addr=%h required 0 00000", gpu_rden, gpu_addr);
        end
        n_cmp++;
        if (dat_valid !== 1'b0 || dat_last !== 1'b0 || dat_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_dat: valid=%b last=%b data=%h required 0 0 0", dat_valid, dat_last, dat_data);
        end
        bus_rst = 1'b0;
        tick();
        n_cmp++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: req_ready=%b busy=%b required 1 0", req_ready, busy);
        end
    endtask

    task automatic test_single_word();
        bit found;
        dat_ready = 1'b1;
        start_burst(20'h01234, 5'd0);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            found = gv_driven;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL single_return: no read returned within 40 cycles, required one");
        end
        n_cmp++;
        if (dat_valid !== 1'b1 || dat_data !== 32'hDEADBEEF || dat_last !== 1'b1) begin
            n_err++;
            $display("FAIL single_latency: valid=%b data=%h last=%b required 1 deadbeef 1",
                     dat_valid, dat_data, dat_last);
        end
        n_cmp++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_drain: req_ready=%b busy=%b required 0 1", req_ready, busy);
        end
        tick();
        n_cmp++;
        if (!did_pop_last || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: popped_last=%b req_ready=%b busy=%b required 1 1 0",
                     did_pop_last, req_ready, busy);
        end
    endtask

    task automatic test_backpressure();
        int base_issue;
        int base_pop;
        dat_ready  = 1'b0;
        base_issue = issue_cnt;
        base_pop   = pop_cnt;
        start_burst(20'h00100, 5'd15);
        repeat (120) tick();
        n_cmp++;
        if (issue_cnt - base_issue != 8 || gpu_rden !== 1'b0) begin
            n_err++;
            $display("FAIL bp_credit: issues=%0d gpu_rden=%b required 8 0", issue_cnt - base_issue, gpu_rden);
        end
        n_cmp++;
        if (dat_valid !== 1'b1 || dat_data !== mem_word(20'h00100)) begin
            n_err++;
            $display("FAIL bp_head: valid=%b data=%h required 1 %h", dat_valid, dat_data, mem_word(20'h00100));
        end
        dat_ready = 1'b1;
        drain("bp", 600);
        n_cmp++;
        if (pop_cnt - base_pop != 16) begin
            n_err++;
            $display("FAIL bp_count: words=%0d required 16", pop_cnt - base_pop);
        end
    endtask

    task automatic test_wrap();
        dat_ready = 1'b1;
        start_burst(20'hFFFF8, 5'd3);
        drain("wrap", 200);
        n_cmp++;
        if (gpu_addr !== 20'h00008) begin
            n_err++;
            $display("FAIL wrap_end_addr: gpu_addr=%h required 00008", gpu_addr);
        end
    endtask

    task automatic test_slot_gating();
        int base_issue;
        dat_ready  = 1'b1;
        slot_en    = 1'b0;
        base_issue = issue_cnt;
        start_burst(20'h00200, 5'd1);
        repeat (16) tick();
        n_cmp++;
        if (issue_cnt != base_issue || gpu_addr !== 20'h00200 || gpu_rden !== 1'b1) begin
            n_err++;
            $display("FAIL slot_blocked: issues=%0d gpu_addr=%h gpu_rden=%b required 0 00200 1",
                     issue_cnt - base_issue, gpu_addr, gpu_rden);
        end
        slot_en = 1'b1;
        drain("slot", 200);
        n_cmp++;
        if (issue_cnt - base_issue != 2) begin
            n_err++;
            $display("FAIL slot_open: issues=%0d required 2", issue_cnt - base_issue);
        end
    endtask

    task automatic test_back_to_back();
        int  pop_k;
        int  acc_k;
        bit  rr;
        dat_ready = 1'b1;
        start_burst(20'h00800, 5'd1);
        push_expect(20'h00900, 5'd0);
        req_addr  = 20'h00900;
        req_len   = 5'd0;
        req_valid = 1'b1;
        pop_k     = -1;
        acc_k     = -1;
        for (int k = 0; k < 200 && acc_k < 0; k++) begin
            rr = (req_ready === 1'b1);
            tick();
            if (did_pop_last && pop_k < 0) pop_k = k;
            if (rr) acc_k = k;
        end
        req_valid = 1'b0;
        n_cmp++;
        if (pop_k < 0 || acc_k != pop_k + 1) begin
            n_err++;
            $display("FAIL b2b_accept: accepted at cycle %0d, last pop at %0d, required last pop + 1", acc_k, pop_k);
        end
        drain("b2b", 200);
    endtask

    task automatic test_reset_mid_burst();
        int  base_pop;
        int  k;
        bit  seen;
        dat_ready = 1'b1;
        base_pop  = pop_cnt;
        start_burst(20'h00400, 5'd15);
        k = 0;
        while (pop_cnt - base_pop < 3 && k < 200) begin
            tick();
            k++;
        end
        n_cmp++;
        if (pop_cnt - base_pop != 3) begin
            n_err++;
            $display("FAIL rstmid_progress: words=%0d required 3", pop_cnt - base_pop);
        end
        bus_rst = 1'b1;
        #1;
        n_cmp++;
        if (gpu_rden !== 1'b0 || dat_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_async: gpu_rden=%b dat_valid=%b busy=%b required 0 0 0",
                     gpu_rden, dat_valid, busy);
        end
        exp_q.delete();
        exp_addr.delete();
        tick();
        tick();
        bus_rst     = 1'b0;
        spurious_en = 1'b1;
        spur_data   = 32'hCAFEF00D;
        tick();
        spurious_en = 1'b0;
        seen        = (dat_valid !== 1'b0);
        repeat (12) begin
            tick();
            if (dat_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_stale: dat_valid seen=%b busy=%b required 0 0", seen, busy);
        end
    endtask

    task automatic test_spurious();
        spurious_en = 1'b1;
        spur_data   = 32'h12345678;
        tick();
        spurious_en = 1'b0;
        n_cmp++;
        if (dat_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL spurious_now: dat_valid=%b busy=%b required 0 0", dat_valid, busy);
        end
        tick();
        tick();
        n_cmp++;
        if (dat_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL spurious_after: dat_valid=%b req_ready=%b required 0 1", dat_valid, req_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_rst     = 1'b1;
        ram_cyc     = 4'b0001;
        ram_acc     = 4'b1010;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_len     = '0;
        gpu_rdata   = '0;
        gpu_valid   = 1'b0;
        dat_ready   = 1'b0;
        slot_en     = 1'b1;
        spurious_en = 1'b0;
        spur_data   = '0;

        test_reset();
        test_spurious();
        test_single_word();
        test_backpressure();
        test_wrap();
        test_slot_gating();
        test_back_to_back();
        test_reset_mid_burst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
